// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the control circuit's
// next-state logic: FSM state encoding, instruction field layout, HALT opcode
// and default parameter values.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_ISSUE  = 3'd3,
        S_RETIRE = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } seq_state_t;

    localparam int             IW_DEF      = 9;
    localparam int             AW_DEF      = 4;
    localparam int             TIMEOUT_DEF = 15;
    localparam int             OP_W        = 3;
    localparam logic [OP_W-1:0] HALT_OP_DEF = 3'b111;

    // Register fields, counted from the LSB: rx = [5:3], ry = [2:0].
    localparam int RX_LSB = 3;
    localparam int RY_LSB = 0;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: ROM read port plus the instruction/start/done handshake to
// the control unit.
//   master : sequencer side (drives mem_addr, instruction, start)
//   slave  : ROM / control-unit side (drives mem_rdata, cu_done)
interface instr_sequencer_if #(
    parameter int IW = 9,
    parameter int AW = 4
);
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_rdata;
    logic [IW-1:0] instruction;
    logic          start;
    logic          cu_done;

    modport master (
        output mem_addr, instruction, start,
        input  mem_rdata, cu_done
    );

    modport slave (
        input  mem_addr, instruction, start,
        output mem_rdata, cu_done
    );
endinterface

// File: rtl/instr_sequencer_watchdog.sv
// seq_watchdog: counts cycles the sequencer waits for cu_done.
//   clk, rst : clock, async active-high reset
//   clear    : zero the counter (asserted while latching a new instruction)
//   enable   : count this cycle (asserted while in ISSUE)
//   expired  : counter has reached TIMEOUT-1
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT - 1));

    // Saturates at the expiry value; the sequencer leaves ISSUE that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= '0;
        else if (clear)               cnt <= '0;
        else if (enable && !expired)  cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: program sequencer in front of the 9-bit control unit.
// Fetches from a 1-cycle-latency ROM at pc, presents each instruction with
// start held high until cu_done, then advances pc. Free-run (run) and
// single-step (step) modes, HALT opcode, and a cu_done watchdog.
//   clk, rst           : clock, async active-high reset
//   run                : level, free-run while high
//   step               : one-cycle pulse, run one instruction (IDLE only)
//   bus (master)       : mem_addr/mem_rdata ROM port, instruction/start/cu_done
//   pc                 : program counter (mem_addr mirrors it)
//   busy               : high in FETCH/LATCH/ISSUE/RETIRE
//   halted, err        : sticky terminal flags, cleared only by rst
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int             IW      = IW_DEF,
    parameter int             AW      = AW_DEF,
    parameter logic [OP_W-1:0] HALT_OP = HALT_OP_DEF,
    parameter int             TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    instr_sequencer_if.master   bus,
    output logic [AW-1:0]       pc,
    output logic                busy,
    output logic                halted,
    output logic                err
);
    seq_state_t    state;
    logic [IW-1:0] instr_q;
    logic          start_q;
    logic          step_mode;
    logic          wdog_expired;

    assign bus.mem_addr    = pc;
    assign bus.instruction = instr_q;
    assign bus.start       = start_q;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_LATCH),
        .enable  (state == S_ISSUE),
        .expired (wdog_expired)
    );

    // Outputs are registered alongside the state so start/busy change on the
    // same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            instr_q   <= '0;
            start_q   <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
            step_mode <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state     <= S_FETCH;
                        step_mode <= 1'b0;
                        busy      <= 1'b1;
                    end else if (step) begin
                        state     <= S_FETCH;
                        step_mode <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                // ROM sees pc this cycle; data is valid in LATCH.
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    instr_q <= bus.mem_rdata;
                    if (bus.mem_rdata[IW-1 -: OP_W] == HALT_OP) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state   <= S_ISSUE;
                        start_q <= 1'b1;
                    end
                end
                // cu_done has priority over a same-cycle timeout.
                S_ISSUE: begin
                    if (bus.cu_done) begin
                        state   <= S_RETIRE;
                        start_q <= 1'b0;
                    end else if (wdog_expired) begin
                        state   <= S_ERR;
                        start_q <= 1'b0;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                S_RETIRE: begin
                    pc <= pc + 1'b1;
                    if (run && !step_mode) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_HALT, S_ERR: state <= state;
                default: begin
                    state   <= S_IDLE;
                    start_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    localparam int IW = 9;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic step = 1'b0;
    logic [AW-1:0] pc;
    logic busy, halted, err;

    int total = 0;
    int bad = 0;

    logic [IW-1:0] rom [0:(1<<AW)-1];
    int cu_lat = 3;
    logic cu_en = 1'b1;
    int cu_cnt = 0;
    logic prev_start = 1'b0;

    iss_t exp_q[$];
    iss_t obs_q[$];

    instr_sequencer_if #(.IW(IW), .AW(AW)) bus ();

    instr_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .step   (step),
        .bus    (bus),
        .pc     (pc),
        .busy   (busy),
        .halted (halted),
        .err    (err)
    );

    always #5 clk = ~clk;

    // ROM model, one-cycle read latency
    always @(posedge clk) bus.mem_rdata <= rom[bus.mem_addr];

    // Control-unit model: cu_done on the cu_lat-th cycle of start
    always @(posedge clk) begin
        if (!bus.start) cu_cnt <= 0;
        else            cu_cnt <= cu_cnt + 1;
    end
    assign bus.cu_done = cu_en && bus.start && (cu_cnt == cu_lat - 1);

    // Record every issued instruction at its start rising edge
    always @(negedge clk) begin
        if (bus.start && !prev_start) obs_q.push_back('{pc: pc, ins: bus.instruction});
        prev_start <= bus.start;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        step = 1'b0;
        cu_en = 1'b1;
        cu_lat = 3;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic fill_plain_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 9'(i * 5 + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", bus.start); end
        total++; if (pc !== '0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (halted !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", halted, err); end
        total++; if (bus.instruction !== '0) begin bad++; $display("FAIL reset_instr got=%h exp=0", bus.instruction); end
        do_reset();
    endtask

    task automatic test_run_halt();
        int n;
        do_reset();
        fill_plain_rom();
        rom[0] = 9'b000_001_000;  // LOAD r1
        rom[1] = 9'b001_010_001;  // MOVE r2<-r1
        rom[2] = 9'b111_000_000;  // HALT
        exp_q.push_back('{pc: 4'd0, ins: rom[0]});
        exp_q.push_back('{pc: 4'd1, ins: rom[1]});
        run = 1'b1;
        n = 0;
        while (!halted && n < 200) begin tick(); n++; end
        total++; if (!halted) begin bad++; $display("FAIL halt_timeout got halted=%b exp=1", halted); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL halt_issue_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            iss_t e = exp_q.pop_front();
            iss_t o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL halt_issue got pc=%0d ins=%h exp pc=%0d ins=%h", o.pc, o.ins, e.pc, e.ins); end
        end
        repeat (5) tick();
        total++; if (pc !== 4'd2) begin bad++; $display("FAIL halt_pc got=%0d exp=2", pc); end
        total++; if (bus.start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL halt_idle got start=%b busy=%b exp 0 0", bus.start, busy); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL halt_no_issue got=%0d exp=0", obs_q.size()); end
        run = 1'b0;
    endtask

    task automatic test_step();
        int n;
        logic stray_busy;
        do_reset();
        fill_plain_rom();
        exp_q.push_back('{pc: 4'd0, ins: rom[0]});
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick();
        step = 1'b1; tick(); step = 1'b0;  // while busy: must be ignored
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        stray_busy = 1'b0;
        repeat (10) begin tick(); if (busy) stray_busy = 1'b1; end
        total++; if (stray_busy) begin bad++; $display("FAIL step_rebusy got=1 exp=0"); end
        total++; if (pc !== 4'd1) begin bad++; $display("FAIL step_pc got=%0d exp=1", pc); end
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL step_issue_count got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            iss_t e = exp_q.pop_front();
            iss_t o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL step_issue got pc=%0d ins=%h exp pc=%0d ins=%h", o.pc, o.ins, e.pc, e.ins); end
        end
    endtask

    task automatic test_timeout();
        int n, hi;
        do_reset();
        fill_plain_rom();
        cu_en = 1'b0;
        run = 1'b1;
        n = 0; hi = 0;
        while (!err && n < 100) begin tick(); n++; if (bus.start) hi++; end
        total++; if (!err) begin bad++; $display("FAIL wdog_err got=%b exp=1", err); end
        total++; if (hi != 15) begin bad++; $display("FAIL wdog_issue_cycles got=%0d exp=15", hi); end
        repeat (20) tick();
        total++; if (err !== 1'b1 || bus.start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wdog_sticky got err=%b start=%b busy=%b exp 1 0 0", err, bus.start, busy); end
        total++; if (pc !== 4'd0 || halted !== 1'b0) begin bad++; $display("FAIL wdog_pc got pc=%0d halted=%b exp 0 0", pc, halted); end
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL wdog_issue_count got=%0d exp=1", obs_q.size()); end
        run = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        fill_plain_rom();
        cu_lat = 1;
        for (int i = 0; i <= (1 << AW); i++) exp_q.push_back('{pc: AW'(i), ins: rom[i % (1 << AW)]});
        run = 1'b1;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 400) begin tick(); n++; end
        run = 1'b0;
        total++; if (obs_q.size() < exp_q.size()) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            iss_t e = exp_q.pop_front();
            iss_t o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL wrap_issue got pc=%0d ins=%h exp pc=%0d ins=%h", o.pc, o.ins, e.pc, e.ins); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        fill_plain_rom();
        run = 1'b1;
        n = 0;
        while (obs_q.size() < 2 && n < 100) begin tick(); n++; end
        total++; if (pc !== 4'd1 || bus.start !== 1'b1) begin bad++; $display("FAIL arst_pre got pc=%0d start=%b exp 1 1", pc, bus.start); end
        #1 rst = 1'b1;
        #1;
        total++; if (bus.start !== 1'b0 || pc !== '0 || busy !== 1'b0) begin bad++; $display("FAIL arst_async got start=%b pc=%0d busy=%b exp 0 0 0", bus.start, pc, busy); end
        do_reset();
    endtask

    task automatic test_run_drop();
        int n;
        logic stray_busy;
        do_reset();
        fill_plain_rom();
        exp_q.push_back('{pc: 4'd0, ins: rom[0]});
        run = 1'b1;
        n = 0;
        while (obs_q.size() < 1 && n < 50) begin tick(); n++; end
        run = 1'b0;
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        stray_busy = 1'b0;
        repeat (10) begin tick(); if (busy) stray_busy = 1'b1; end
        total++; if (stray_busy || busy) begin bad++; $display("FAIL drop_refetch got busy=1 exp=0"); end
        total++; if (pc !== 4'd1) begin bad++; $display("FAIL drop_pc got=%0d exp=1", pc); end
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL drop_issue_count got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            iss_t e = exp_q.pop_front();
            iss_t o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL drop_issue got pc=%0d ins=%h exp pc=%0d ins=%h", o.pc, o.ins, e.pc, e.ins); end
        end
    endtask

    initial begin
        fill_plain_rom();
        test_reset();
        test_run_halt();
        test_step();
        test_timeout();
        test_wrap();
        test_async_reset();
        test_run_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
